// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg
// Shared types and defaults for the SDRAM three-port burst arbiter.
//   port_sel_t  : which requester port owns the current burst (or none)
//   arb_state_t : arbiter sequencing states
//   BURST_LEN_DEFAULT / ADDR_W_DEFAULT : default words per burst and
//                                        forwarded address width
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_P1   = 2'd1,
        SEL_P2   = 2'd2,
        SEL_P3   = 2'd3
    } port_sel_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BURST = 2'd1,
        ARB_GAP   = 2'd2
    } arb_state_t;

    localparam int BURST_LEN_DEFAULT = 4;
    localparam int ADDR_W_DEFAULT    = 24;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if
// Bundles the three requester ports and the SDRAM controller side.
//   p1_*  : program-cache fill port (read only)
//   p2_*  : data-cache fill/writeback port
//   p3_*  : video/DMA port (24-bit address)
//   mem_* : single burst port toward the SDRAM controller
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (requesters + controller)
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int OFF_W  = 2
);
    logic              p1_req;
    logic [31:0]       p1_address;
    logic              p1_ready;
    logic [OFF_W-1:0]  p1_offset;

    logic              p2_req;
    logic              p2_wren;
    logic [31:0]       p2_address;
    logic [15:0]       p2_to_mem;
    logic              p2_ready;
    logic [OFF_W-1:0]  p2_offset;

    logic              p3_req;
    logic              p3_wren;
    logic [23:0]       p3_address;
    logic [15:0]       p3_to_mem;
    logic              p3_ready;
    logic [OFF_W-1:0]  p3_offset;

    logic              mem_req;
    logic              mem_wren;
    logic [ADDR_W-1:0] mem_address;
    logic [15:0]       mem_to_mem;
    logic              mem_ready;
    logic [OFF_W-1:0]  mem_offset;

    modport slave (
        input  p1_req, p1_address,
        input  p2_req, p2_wren, p2_address, p2_to_mem,
        input  p3_req, p3_wren, p3_address, p3_to_mem,
        input  mem_ready, mem_offset,
        output p1_ready, p1_offset, p2_ready, p2_offset, p3_ready, p3_offset,
        output mem_req, mem_wren, mem_address, mem_to_mem
    );

    modport master (
        output p1_req, p1_address,
        output p2_req, p2_wren, p2_address, p2_to_mem,
        output p3_req, p3_wren, p3_address, p3_to_mem,
        output mem_ready, mem_offset,
        input  p1_ready, p1_offset, p2_ready, p2_offset, p3_ready, p3_offset,
        input  mem_req, mem_wren, mem_address, mem_to_mem
    );

endinterface

// File: rtl/sdram_arb_pick.sv
// sdram_arb_pick
// Combinational winner selection among the three burst requesters.
// Build option: SDRAM_ARB_ROUND_ROBIN_EN
//   defined   : round-robin, the port after last_grant has top priority
//   undefined : fixed priority p3 > p2 > p1
// Ports:
//   req        in  [2:0]  request vector, bit0 = p1 .. bit2 = p3
//   last_grant in         port granted for the previous burst
//   pick       out        winning port, SEL_NONE when nothing requests
import sdram_arb_pkg::*;

module sdram_arb_pick (
    input  logic [2:0] req,
    input  port_sel_t  last_grant,
    output port_sel_t  pick
);

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    always_comb begin
        pick = SEL_NONE;
        case (last_grant)
            SEL_P1: begin
                if (req[1])      pick = SEL_P2;
                else if (req[2]) pick = SEL_P3;
                else if (req[0]) pick = SEL_P1;
            end
            SEL_P2: begin
                if (req[2])      pick = SEL_P3;
                else if (req[0]) pick = SEL_P1;
                else if (req[1]) pick = SEL_P2;
            end
            default: begin
                // last grant p3 (reset value) or none: p1 leads
                if (req[0])      pick = SEL_P1;
                else if (req[1]) pick = SEL_P2;
                else if (req[2]) pick = SEL_P3;
            end
        endcase
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    always_comb begin
        pick = SEL_NONE;
        if (req[2])      pick = SEL_P3;
        else if (req[1]) pick = SEL_P2;
        else if (req[0]) pick = SEL_P1;
    end
`endif

endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Three-port burst arbiter in front of a single-port SDRAM controller.
// One port owns each burst; its address/wren/write data go to the
// controller and the controller's ready/offset strobes return to it only.
// Build option: SDRAM_ARB_ROUND_ROBIN_EN (selects arbitration in sdram_arb_pick)
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   asynchronous active-high reset
//   bus  slave modport of sdram_port_arbiter_if (requesters + controller)
import sdram_arb_pkg::*;

module sdram_port_arbiter #(
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int BURST_LEN = BURST_LEN_DEFAULT,
    parameter int OFF_W     = $clog2(BURST_LEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    sdram_port_arbiter_if.slave   bus
);

    localparam logic [1:0] ST_IDLE  = ARB_IDLE;
    localparam logic [1:0] ST_BURST = ARB_BURST;
    localparam logic [1:0] ST_GAP   = ARB_GAP;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(BURST_LEN - 1);

    logic [1:0]       state;
    port_sel_t        grant;
    port_sel_t        last_grant;
    port_sel_t        pick;
    logic [OFF_W-1:0] word_cnt;
    logic             mem_req_q;
    logic [2:0]       req_vec;
    logic [31:0]      p3_address_ext;
    logic             granted_req;

    assign req_vec        = {bus.p3_req, bus.p2_req, bus.p1_req};
    assign p3_address_ext = {8'h00, bus.p3_address};
    assign bus.mem_req    = mem_req_q;

    sdram_arb_pick u_pick (
        .req        (req_vec),
        .last_grant (last_grant),
        .pick       (pick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant      <= SEL_NONE;
            last_grant <= SEL_P3;
            word_cnt   <= '0;
            mem_req_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req_vec) begin
                        grant     <= pick;
                        mem_req_q <= 1'b1;
                        word_cnt  <= '0;
                        state     <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (bus.mem_ready) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (word_cnt == LAST_WORD) begin
                            // grant is released here so nothing is routed during GAP
                            mem_req_q  <= 1'b0;
                            last_grant <= grant;
                            grant      <= SEL_NONE;
                            state      <= ST_GAP;
                        end
                    end
                end
                ST_GAP:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // grant is SEL_NONE outside BURST, so every output idles at 0 there
    always_comb begin
        bus.mem_wren    = 1'b0;
        bus.mem_address = '0;
        bus.mem_to_mem  = '0;
        bus.p1_ready    = 1'b0;
        bus.p1_offset   = '0;
        bus.p2_ready    = 1'b0;
        bus.p2_offset   = '0;
        bus.p3_ready    = 1'b0;
        bus.p3_offset   = '0;
        granted_req     = 1'b0;
        case (grant)
            SEL_P1: begin
                bus.mem_address = bus.p1_address[ADDR_W-1:0];
                bus.p1_ready    = bus.mem_ready;
                bus.p1_offset   = bus.mem_offset;
                granted_req     = bus.p1_req;
            end
            SEL_P2: begin
                bus.mem_wren    = bus.p2_wren;
                bus.mem_address = bus.p2_address[ADDR_W-1:0];
                bus.mem_to_mem  = bus.p2_to_mem;
                bus.p2_ready    = bus.mem_ready;
                bus.p2_offset   = bus.mem_offset;
                granted_req     = bus.p2_req;
            end
            SEL_P3: begin
                bus.mem_wren    = bus.p3_wren;
                bus.mem_address = p3_address_ext[ADDR_W-1:0];
                bus.mem_to_mem  = bus.p3_to_mem;
                bus.p3_ready    = bus.mem_ready;
                bus.p3_offset   = bus.mem_offset;
                granted_req     = bus.p3_req;
            end
            default: ;
        endcase
    end

    // requester must hold req through its last word; the burst cannot abort
    a_req_held: assert property (@(posedge clk) disable iff (rst)
        (state == ST_BURST) |-> granted_req);

    // controller offset should track our word count
    a_offset_sync: assert property (@(posedge clk) disable iff (rst)
        (state == ST_BURST && bus.mem_ready) |-> (bus.mem_offset == word_cnt));

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Three-port burst arbiter between the cache/video requesters and the single-port SDRAM controller.
- Port 1 is the program-cache fill port (read only); port 2 is the data-cache fill/writeback port (read/write); port 3 is the video/DMA port (read/write).
- Grants one port per burst and forwards its address, write data and wren to the controller.
- Routes the controller's per-word ready/offset strobes back to the granted port only; read data is broadcast to all ports.

Parameters:
- ADDR_W, 24, word address width forwarded to the controller; wider port addresses are truncated to the low ADDR_W bits.
- BURST_LEN, 4, words per burst; must be a power of two, 2..16.
- OFF_W, 2, offset width; equals log2(BURST_LEN).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- p1_req  in  1  program-cache burst request; held until the last ready.
- p1_address  in  32  p1 burst base address.
- p1_ready  out  1  word-valid strobe to p1.
- p1_offset  out  OFF_W  word index within the current p1 burst.
- p2_req  in  1  data-cache burst request.
- p2_wren  in  1  1 = writeback burst, 0 = fill.
- p2_address  in  32  p2 burst base address.
- p2_to_mem  in  16  p2 write data for the current offset.
- p2_ready  out  1  word strobe to p2.
- p2_offset  out  OFF_W  word index to p2.
- p3_req, p3_wren, p3_address[23:0], p3_to_mem[15:0]  in  port 3 request bundle; same meaning as the p2 bundle.
- p3_ready  out  1  word strobe to p3.
- p3_offset  out  OFF_W  word index to p3.
- mem_req  out  1  burst request to the controller.
- mem_wren  out  1  burst direction to the controller.
- mem_address  out  ADDR_W  burst base address to the controller.
- mem_to_mem  out  16  write data from the granted port.
- mem_ready  in  1  controller word strobe.
- mem_offset  in  OFF_W  controller word index.

Behaviour:
- Reset values: state IDLE, grant none, all outputs 0. Reset may assert mid-burst: mem_req drops asynchronously. The controller is reset from the same rst.
- States:
  - IDLE: if any req is high, register the winner, mem_req <= 1, go to BURST. First mem_req is one cycle after the requesting req rises.
  - BURST: address, wren and write data are muxed combinationally from the granted port. mem_ready/mem_offset are copied combinationally to pX_ready/pX_offset of the granted port; other ports see 0.
  - Word counter: 0 to BURST_LEN-1, increments on each mem_ready. On mem_ready with counter == BURST_LEN-1: mem_req <= 0, go to GAP.
  - GAP: one idle cycle so the requester can drop req. Then go to IDLE.
- A port's req that stays high after GAP is treated as a new request.
- Port 1 never writes: when p1 is granted, mem_wren = 0 and mem_to_mem = 0.
- A req that drops before its last word completes is ignored; the burst runs to completion (the controller cannot abort). This is a protocol violation and is flagged by an assertion in simulation.
- If mem_offset differs from the word counter on a mem_ready, the routing is unaffected; a simulation assertion fires.
- Requests arriving in BURST or GAP wait. A req is never lost while it is held.
- Arbitration is evaluated only in IDLE; simultaneous requests are resolved per the optional feature below.

Optional Feature:
- Macro: SDRAM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin. The port after the last-granted one has highest priority, rotating p1 -> p2 -> p3 -> p1. The last-grant register resets to p3, so p1 wins first after reset.
- Undefined: fixed priority p3 > p2 > p1 (video first, writeback before fetch).

Decomposition:
- Shared package sdram_arb_pkg holds:
  - typedef port_sel_t enum {SEL_NONE, SEL_P1, SEL_P2, SEL_P3};
  - typedef arb_state_t enum {ARB_IDLE, ARB_BURST, ARB_GAP};
  - constants BURST_LEN_DEFAULT = 4 and ADDR_W_DEFAULT = 24.
- One sub-module, sdram_arb_pick: combinational priority/round-robin picker taking the req vector and the last grant, returning port_sel_t. It contains the only ifdef.

Test Plan:
- Single p1 fill: p1_req=1, address 0x000100; the controller returns 4 readies at offsets 0..3 -> mem_address=0x000100, mem_wren=0, four p1_ready pulses, p2_ready and p3_ready stay 0, mem_req falls after offset 3, one GAP cycle.
- p2 writeback: p2_wren=1, address 0x001240, data 0xA000+offset -> mem_wren=1, mem_to_mem tracks p2_to_mem per offset, and the SDRAM model holds 0xA000..0xA003 at 0x1240..0x1243.
- Simultaneous p1, p2 and p3 held high, fixed priority -> grant order p3, p2, p1, each burst 4 words, GAP between bursts.
- Same stimulus with SDRAM_ARB_ROUND_ROBIN_EN -> grant order p1, p2, p3, then p1 again if p1 is re-requested.
- p3 request arrives mid p1 burst (at offset 1) -> p1 finishes all 4 words, then p3 is granted after GAP with no loss of either.
- rst pulsed at offset 2 of a p2 burst -> mem_req=0 and all readies 0 immediately; after release, a fresh p2_req produces a full 4-word burst starting at offset 0.
